// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word size, fetch constants and the fetch FSM state type.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HOLD
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load an instruction or a bubble.
module if_id_register
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // A bubble keeps the last PC so decode always sees a meaningful id_pc.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (load_valid) begin
        instr_d = load_instr;
        pc_d    = load_pc;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign id_instruction = instr_q;
  assign id_pc          = pc_q;
  assign id_valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem req/ready handshake, and feeds the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] id_instruction,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            imem_req_q, imem_req_d;

  logic            xfer;
  logic [XLEN-1:0] redir_pc;
  logic            load_valid;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  assign xfer     = imem_req_q & imem_ready;
  assign redir_pc = word_align(redirect_pc);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load_valid   = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = addr_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) addr_d = redir_pc;
      end
      S_REQ: begin
        if (redirect_valid) begin
          // Without a transfer the request must stay stable, so drain it at the old address.
          if (xfer) begin
            addr_d = redir_pc;
          end else begin
            pc_d    = redir_pc;
            state_d = S_DRAIN;
          end
        end else if (xfer) begin
          addr_d = addr_q + PC_INCR;
          if (id_stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = addr_q;
            state_d      = S_HOLD;
          end else begin
            load_valid = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_valid) pc_d = redir_pc;
        if (xfer) begin
          addr_d  = redirect_valid ? redir_pc : pc_q;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          addr_d  = redir_pc;
          state_d = S_REQ;
        end else if (!id_stall) begin
          load_valid = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    imem_req_d = (state_d == S_REQ) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= RESET_PC;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      imem_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      imem_req_q   <= imem_req_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = addr_q;

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk            (clk),
    .rst            (rst),
    .flush          (redirect_valid),
    .stall          (id_stall),
    .load_valid     (load_valid),
    .load_instr     (load_instr),
    .load_pc        (load_pc),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory returns address-tagged words; a transaction-level scoreboard
// tracks which fetched words must reach decode, in order, and checks id_* every cycle.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        id_valid;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h3C00_0001;
  endfunction

  assign imem_rdata = tag(imem_addr);

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard state: words owed to decode, and what the fetch address should be.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       sb_q[$];
  item_t       it;
  logic [31:0] exp_fetch;
  logic [31:0] taint_addr;
  bit          tainted;
  bit          pending;
  bit          m_valid;
  logic [31:0] m_ins;
  logic [31:0] m_pc;
  bit          mon_en = 1'b0;
  bit          s_xfer, s_redir, s_stall;
  logic [31:0] s_rpc;

  task automatic model_reset();
    exp_fetch = 32'h0;
    taint_addr = 32'h0;
    tainted = 1'b0;
    pending = 1'b0;
    sb_q.delete();
    m_valid = 1'b0;
    m_ins = NOP;
    m_pc = 32'h0;
  endtask

  // Monitor: sample the handshake at the edge, check id_* half a cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (mon_en && !rst) begin
        s_xfer  = imem_req && imem_ready;
        s_redir = redirect_valid;
        s_stall = id_stall;
        s_rpc   = redirect_pc & 32'hFFFF_FFFC;
        if (imem_req) chk("imem_addr", imem_addr, tainted ? taint_addr : exp_fetch);
        if (pending) chk("req_held", 32'(imem_req), 32'd1);
        pending = imem_req && !imem_ready;
        // A fetch that was in flight when a redirect arrived is stale and never reaches decode.
        if (s_xfer) begin
          if (!tainted) begin
            if (!s_redir) begin
              it.pc  = exp_fetch;
              it.ins = tag(exp_fetch);
              sb_q.push_back(it);
            end
            exp_fetch = exp_fetch + 32'd4;
          end
          tainted = 1'b0;
        end else if (s_redir && imem_req) begin
          if (!tainted) taint_addr = exp_fetch;
          tainted = 1'b1;
        end
        if (s_redir) begin
          exp_fetch = s_rpc;
          sb_q.delete();
          m_valid = 1'b0;
          m_ins = NOP;
        end else if (!s_stall) begin
          if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            m_valid = 1'b1;
            m_ins = it.ins;
            m_pc = it.pc;
          end else begin
            m_valid = 1'b0;
            m_ins = NOP;
          end
        end
        @(negedge clk);
        if (mon_en && !rst) begin
          chk("id_valid", 32'(id_valid), 32'(m_valid));
          chk("id_instruction", id_instruction, m_ins);
          if (m_valid) chk("id_pc", id_pc, m_pc);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_req"}, 32'(imem_req), 32'd0);
    chk({pfx, "_addr"}, imem_addr, 32'h0);
    chk({pfx, "_instr"}, id_instruction, NOP);
    chk({pfx, "_pc"}, id_pc, 32'h0);
    chk({pfx, "_valid"}, 32'(id_valid), 32'd0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    imem_ready = 1'b1;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    for (int i = 0; i < 64 && !(imem_req && imem_addr == a); i++) cyc(1);
    chk("reach_addr", imem_addr, a);
  endtask

  initial begin
    imem_ready = 1'b1;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");

    // 1: streaming from reset
    do_reset();
    chk("req_after_release", 32'(imem_req), 32'd0);
    cyc(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("valid_cycle1", 32'(id_valid), 32'd0);
    cyc(1);
    chk("valid_cycle2", 32'(id_valid), 32'd1);
    chk("pc_cycle2", id_pc, 32'h0);
    cyc(3);
    chk("pc_cycle5", id_pc, 32'hC);

    // 2: memory not ready for three cycles at 0x10
    do_reset();
    wait_addr(32'h10);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t2_addr", imem_addr, 32'h10);
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_bubble", 32'(id_valid), 32'd0);
    end
    imem_ready = 1'b1;
    cyc(1);
    chk("t2_pc", id_pc, 32'h10);
    chk("t2_valid", 32'(id_valid), 32'd1);

    // 3: decode stall while the 0x8 transfer completes
    do_reset();
    wait_addr(32'h8);
    id_stall = 1'b1;
    cyc(2);
    chk("t3_held_pc", id_pc, 32'h4);
    id_stall = 1'b0;
    cyc(1);
    chk("t3_pc8", id_pc, 32'h8);
    cyc(1);
    chk("t3_pcC", id_pc, 32'hC);

    // 4: redirect while a request to 0x20 waits on ready
    do_reset();
    wait_addr(32'h20);
    imem_ready = 1'b0;
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t4_flush", 32'(id_valid), 32'd0);
    chk("t4_old_addr", imem_addr, 32'h20);
    imem_ready = 1'b1;
    cyc(1);
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_discard", 32'(id_valid), 32'd0);
    cyc(1);
    chk("t4_pc", id_pc, 32'h100);

    // 5: redirect together with a decode stall holding a buffered word
    do_reset();
    wait_addr(32'h10);
    id_stall = 1'b1;
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cyc(1);
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    chk("t5_flush", 32'(id_valid), 32'd0);
    chk("t5_addr", imem_addr, 32'h200);
    cyc(1);
    chk("t5_pc", id_pc, 32'h200);

    // 6: unaligned redirect near the top of memory wraps to zero
    do_reset();
    cyc(2);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1);
    chk("t6_addr_wrap", imem_addr, 32'h0);
    chk("t6_pc_top", id_pc, 32'hFFFF_FFFC);

    // 6b: asynchronous reset while draining a stale request
    do_reset();
    cyc(3);
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6b");

    // Random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      id_stall = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else redirect_pc = $urandom & 32'h0000_FFFF;
      cyc(1);
    end
    imem_ready = 1'b1;
    id_stall = 1'b0;
    redirect_valid = 1'b0;
    cyc(6);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
